cw310_reg_aes_batch: RTL

- Parametrised successor to the single-shot crypto register block.
- Host queues up to pDEPTH plaintexts over the register bus. An internal sequencer feeds them one at a time to the crypto core and queues the ciphertexts in an output FIFO for readback.
- Adds a job counter, a done-timeout, sticky error flags, optional external-trigger gating and flush.
- Single clock domain: the crypto core runs on usb_clk.

---
 rtl/cw310_reg_aes_batch.sv | 329 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cw310_reg_aes_batch.sv
// rtl/cw310_reg_aes_batch.sv - batched crypto register block with plaintext/ciphertext FIFOs
//
// Purpose: the host loads a key and queues plaintexts over the byte-wide
// register bus. A small sequencer hands queued plaintexts to the crypto core
// one at a time and queues the results for readback. It also keeps a job
// counter, a done-timeout, sticky error flags, optional external-trigger
// gating and a flush control.
//
// Ports:
//   usb_clk        sole clock
//   reset_n_i      asynchronous active-low reset
//   reg_address    register address
//   reg_bytecnt    byte index within a register
//   read_data      combinational read data
//   write_data     write data
//   reg_read       read strobe
//   reg_write      write strobe
//   reg_addrvalid  address valid
//   exttrigger_in  asynchronous external trigger
//   I_cipherout    core result
//   I_ready        core ready
//   I_done         core done (level or pulse)
//   I_busy         core busy (status only)
//   O_key          key register
//   O_textin       head of the plaintext FIFO
//   O_start        one-cycle registered start pulse
//   O_err          OR of the sticky error flags
module cw310_reg_aes_batch #(
  parameter int         pADDR_WIDTH    = 21,
  parameter int         pBYTECNT_SIZE  = 7,
  parameter int         pPT_WIDTH      = 128,
  parameter int         pCT_WIDTH      = 128,
  parameter int         pKEY_WIDTH     = 128,
  parameter int         pDEPTH         = 8,
  parameter int         pTIMEOUT_WIDTH = 16,
  parameter int         pCRYPT_TYPE    = 2,
  parameter int         pCRYPT_REV     = 5,
  parameter logic [7:0] pIDENTIFY      = 8'h2e
) (
  input  logic                                   usb_clk,
  input  logic                                   reset_n_i,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  output logic [7:0]                             read_data,
  input  logic [7:0]                             write_data,
  input  logic                                   reg_read,
  input  logic                                   reg_write,
  input  logic                                   reg_addrvalid,
  input  logic                                   exttrigger_in,
  input  logic [pCT_WIDTH-1:0]                   I_cipherout,
  input  logic                                   I_ready,
  input  logic                                   I_done,
  input  logic                                   I_busy,
  output logic [pKEY_WIDTH-1:0]                  O_key,
  output logic [pPT_WIDTH-1:0]                   O_textin,
  output logic                                   O_start,
  output logic                                   O_err
);

  localparam int RA_W      = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int AW        = $clog2(pDEPTH);
  localparam int CW        = AW + 1;
  localparam int KEY_BYTES = pKEY_WIDTH / 8;
  localparam int PT_BYTES  = pPT_WIDTH / 8;

  localparam logic [RA_W-1:0] A_IDENT  = RA_W'(8'h00);
  localparam logic [RA_W-1:0] A_TYPE   = RA_W'(8'h01);
  localparam logic [RA_W-1:0] A_REV    = RA_W'(8'h02);
  localparam logic [RA_W-1:0] A_CTRL   = RA_W'(8'h03);
  localparam logic [RA_W-1:0] A_STATUS = RA_W'(8'h04);
  localparam logic [RA_W-1:0] A_KEY    = RA_W'(8'h05);
  localparam logic [RA_W-1:0] A_TEXTIN = RA_W'(8'h06);
  localparam logic [RA_W-1:0] A_PUSH   = RA_W'(8'h07);
  localparam logic [RA_W-1:0] A_CTOUT  = RA_W'(8'h08);
  localparam logic [RA_W-1:0] A_POP    = RA_W'(8'h09);
  localparam logic [RA_W-1:0] A_JOBCNT = RA_W'(8'h0A);
  localparam logic [RA_W-1:0] A_ERR    = RA_W'(8'h0B);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic                        r_run;
  logic                        r_ext_gate;
  logic [pKEY_WIDTH-1:0]       r_key;
  logic [pPT_WIDTH-1:0]        r_stage;
  logic [31:0]                 r_jobcnt;
  logic [2:0]                  r_err;
  logic                        r_start;
  logic [pTIMEOUT_WIDTH-1:0]   r_tmo;
  logic                        r_done_q;
  logic [2:0]                  r_trig_sync;

  logic [pPT_WIDTH-1:0]        r_in_mem [pDEPTH];
  logic [AW-1:0]               r_in_wr;
  logic [AW-1:0]               r_in_rd;
  logic [CW-1:0]               r_in_count;
  logic [pCT_WIDTH-1:0]        r_out_mem [pDEPTH];
  logic [AW-1:0]               r_out_wr;
  logic [AW-1:0]               r_out_rd;
  logic [CW-1:0]               r_out_count;

  // Register strobes
  logic w_wr, w_wr_ctrl, w_wr_key, w_wr_text, w_wr_push, w_wr_pop, w_wr_job, w_wr_err;
  logic w_flush;
  logic w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic w_push_ok, w_push_ovf, w_pop_ok, w_pop_unf;
  logic w_done_pulse, w_trig_rise;
  logic w_in_pop, w_out_wr, w_tmo_set, w_job_inc;

  assign w_wr      = reg_write & reg_addrvalid;
  assign w_wr_ctrl = w_wr & (reg_address == A_CTRL);
  assign w_wr_key  = w_wr & (reg_address == A_KEY);
  assign w_wr_text = w_wr & (reg_address == A_TEXTIN);
  assign w_wr_push = w_wr & (reg_address == A_PUSH);
  assign w_wr_pop  = w_wr & (reg_address == A_POP);
  assign w_wr_job  = w_wr & (reg_address == A_JOBCNT);
  assign w_wr_err  = w_wr & (reg_address == A_ERR);
  // Flush is not stored: it acts on the edge that captures the CTRL write.
  assign w_flush   = w_wr_ctrl & write_data[2];

  assign w_in_full   = (r_in_count == CW'(pDEPTH));
  assign w_in_empty  = (r_in_count == '0);
  assign w_out_full  = (r_out_count == CW'(pDEPTH));
  assign w_out_empty = (r_out_count == '0);

  // Fullness is judged on the pre-edge count, so a pop by the sequencer in
  // the same cycle never makes room for the push.
  assign w_push_ok  = w_wr_push & ~w_in_full;
  assign w_push_ovf = w_wr_push & w_in_full;
  assign w_pop_ok   = w_wr_pop & ~w_out_empty;
  assign w_pop_unf  = w_wr_pop & w_out_empty;

  assign w_done_pulse = I_done & ~r_done_q;
  assign w_trig_rise  = r_trig_sync[1] & ~r_trig_sync[2];

  // Sequencer state register
  always_ff @(posedge usb_clk or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Sequencer next state and per-cycle actions
  always_comb begin
    w_state_nxt = r_state;
    w_in_pop    = 1'b0;
    w_out_wr    = 1'b0;
    w_tmo_set   = 1'b0;
    w_job_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_run && !w_in_empty && !w_out_full && I_ready &&
            (!r_ext_gate || w_trig_rise))
          w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_pulse) begin
          w_out_wr    = 1'b1;
          w_state_nxt = S_STORE;
        end else if (&r_tmo) begin
          w_tmo_set   = 1'b1;
          w_in_pop    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_STORE: begin
        w_in_pop    = 1'b1;
        w_job_inc   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A flushed job leaves no trace in the FIFOs or the job counter.
    if (w_flush) begin
      w_state_nxt = S_IDLE;
      w_in_pop    = 1'b0;
      w_out_wr    = 1'b0;
      w_job_inc   = 1'b0;
    end
  end

  // Start pulse, timeout counter, done edge detector and trigger synchroniser
  always_ff @(posedge usb_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_start     <= 1'b0;
      r_tmo       <= '0;
      r_done_q    <= 1'b0;
      r_trig_sync <= '0;
    end else begin
      r_start     <= (w_state_nxt == S_ISSUE);
      r_done_q    <= I_done;
      r_trig_sync <= {r_trig_sync[1:0], exttrigger_in};
      if (r_state == S_ISSUE)     r_tmo <= '0;
      else if (r_state == S_WAIT) r_tmo <= r_tmo + 1'b1;
    end
  end

  // Host-visible control, key, staging, job counter and error flags
  always_ff @(posedge usb_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_run      <= 1'b0;
      r_ext_gate <= 1'b0;
      r_key      <= '0;
      r_stage    <= '0;
      r_jobcnt   <= '0;
      r_err      <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_run      <= write_data[0];
        r_ext_gate <= write_data[1];
      end
      if (w_wr_key && r_state == S_IDLE) begin
        for (int i = 0; i < KEY_BYTES; i++)
          if (reg_bytecnt == pBYTECNT_SIZE'(i)) r_key[8*i +: 8] <= write_data;
      end
      if (w_wr_text) begin
        for (int i = 0; i < PT_BYTES; i++)
          if (reg_bytecnt == pBYTECNT_SIZE'(i)) r_stage[8*i +: 8] <= write_data;
      end
      if (w_wr_job)       r_jobcnt <= '0;
      else if (w_job_inc) r_jobcnt <= r_jobcnt + 32'd1;
      // New events win over a same-cycle clear of the same bit.
      r_err <= (r_err & ~(w_wr_err ? write_data[2:0] : 3'b000)) |
               {w_tmo_set, w_pop_unf, w_push_ovf};
    end
  end

  // Plaintext FIFO
  always_ff @(posedge usb_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < pDEPTH; i++) r_in_mem[i] <= '0;
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_count <= '0;
    end else if (w_flush) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_in_mem[r_in_wr] <= r_stage;
        r_in_wr           <= r_in_wr + 1'b1;
      end
      if (w_in_pop) r_in_rd <= r_in_rd + 1'b1;
      case ({w_push_ok, w_in_pop})
        2'b10:   r_in_count <= r_in_count + 1'b1;
        2'b01:   r_in_count <= r_in_count - 1'b1;
        default: r_in_count <= r_in_count;
      endcase
    end
  end

  // Ciphertext FIFO
  always_ff @(posedge usb_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < pDEPTH; i++) r_out_mem[i] <= '0;
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_out_count <= '0;
    end else if (w_flush) begin
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_out_count <= '0;
    end else begin
      if (w_out_wr) begin
        r_out_mem[r_out_wr] <= I_cipherout;
        r_out_wr            <= r_out_wr + 1'b1;
      end
      if (w_pop_ok) r_out_rd <= r_out_rd + 1'b1;
      case ({w_out_wr, w_pop_ok})
        2'b10:   r_out_count <= r_out_count + 1'b1;
        2'b01:   r_out_count <= r_out_count - 1'b1;
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  // Read path: wide registers are shifted down by the byte index; indices
  // past the register width shift everything out and read 0.
  logic [pKEY_WIDTH-1:0] w_key_sh;
  logic [pPT_WIDTH-1:0]  w_text_sh;
  logic [pCT_WIDTH-1:0]  w_ct_head;
  logic [pCT_WIDTH-1:0]  w_ct_sh;
  logic [31:0]           w_job_sh;
  logic [23:0]           w_status;
  logic [23:0]           w_status_sh;
  logic [7:0]            w_rdata;

  assign w_ct_head   = w_out_empty ? '0 : r_out_mem[r_out_rd];
  assign w_status    = {4'b0000, I_busy, r_run, r_state, 8'(r_out_count), 8'(r_in_count)};
  assign w_key_sh    = r_key     >> {reg_bytecnt, 3'b000};
  assign w_text_sh   = r_stage   >> {reg_bytecnt, 3'b000};
  assign w_ct_sh     = w_ct_head >> {reg_bytecnt, 3'b000};
  assign w_job_sh    = r_jobcnt  >> {reg_bytecnt, 3'b000};
  assign w_status_sh = w_status  >> {reg_bytecnt, 3'b000};

  always_comb begin
    w_rdata = 8'h00;
    if (reg_addrvalid && reg_read) begin
      case (reg_address)
        A_IDENT:  w_rdata = pIDENTIFY;
        A_TYPE:   w_rdata = 8'(pCRYPT_TYPE);
        A_REV:    w_rdata = 8'(pCRYPT_REV);
        A_CTRL:   w_rdata = {6'b000000, r_ext_gate, r_run};
        A_STATUS: w_rdata = w_status_sh[7:0];
        A_KEY:    w_rdata = w_key_sh[7:0];
        A_TEXTIN: w_rdata = w_text_sh[7:0];
        A_CTOUT:  w_rdata = w_ct_sh[7:0];
        A_JOBCNT: w_rdata = w_job_sh[7:0];
        A_ERR:    w_rdata = {5'b00000, r_err};
        default:  w_rdata = 8'h00;
      endcase
    end
  end

  assign read_data = w_rdata;
  assign O_key     = r_key;
  assign O_textin  = r_in_mem[r_in_rd];
  assign O_start   = r_start;
  assign O_err     = |r_err;

endmodule
